// File: rtl/daq_pkg.sv
// Shared DAQ definitions: word width, packet types, packet size limit and the
// upstream arbiter state encoding.
package daq_pkg;

  localparam int DAQ_WORD_W        = 32;
  localparam int DAQ_HDR_WORDS     = 2;
  localparam int DAQ_MAX_PKT_WORDS = 102;

  // Packet type codes carried in the first header word
  localparam logic [7:0] DAQT_CAPTURE = 8'h01;
  localparam logic [7:0] DAQT_STEPPER = 8'h02;
  localparam logic [7:0] DAQT_ENCODER = 8'h03;
  localparam logic [7:0] DAQT_STATUS  = 8'h0F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  function automatic int rr_next(input int idx, input int nreq);
    return (idx + 1 >= nreq) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/daq_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching cyclically.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int OW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   ptr,
  output logic [OW-1:0]   winner,
  output logic            found
);

  int idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = OW'(idx);
      end
    end
  end

endmodule

// File: rtl/daq_arbiter.sv
// Round-robin packet arbiter for the shared DAQ upstream channel.
// Optional macro DAQ_ARB_WATCHDOG_EN adds a grant-to-end watchdog and err_timeout.
module daq_arbiter
  import daq_pkg::*;
#(
  parameter int NREQ          = 4,
  parameter int MAX_PKT_WORDS = DAQ_MAX_PKT_WORDS,
  parameter int SPACE_BITS    = 9,
  parameter int WDOG_CYCLES   = 4096
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              daq_req,
  output logic [NREQ-1:0]              daq_grant,
  input  logic [DAQ_WORD_W*NREQ-1:0]   daq_data,
  input  logic [NREQ-1:0]              daq_valid,
  input  logic [NREQ-1:0]              daq_end,
  output logic [DAQ_WORD_W-1:0]        out_data,
  output logic                         out_valid,
  output logic                         out_end,
  input  logic [SPACE_BITS-1:0]        out_space,
  output logic                         busy,
  output logic [$clog2(NREQ)-1:0]      owner,
`ifdef DAQ_ARB_WATCHDOG_EN
  output logic                         err_timeout,
`endif
  output logic                         err_overflow
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_PKT_WORDS + 1);

  arb_state_t              state, state_nxt;
  logic [NREQ-1:0]         req_q;
  logic [OW-1:0]           rr_ptr;
  logic [OW-1:0]           pick_winner;
  logic                    pick_found;
  logic                    grant_go;
  logic                    own_valid;
  logic                    own_end;
  logic                    word_ok;
  logic [DAQ_WORD_W-1:0]   own_data;
  logic [CW-1:0]           word_cnt;

  // Requests are registered so a level held through the gap is only seen in idle
  rr_pick #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_pick (
    .req    (req_q),
    .ptr    (rr_ptr),
    .winner (pick_winner),
    .found  (pick_found)
  );

  assign own_valid = daq_valid[owner];
  assign own_end   = daq_end[owner];
  assign own_data  = daq_data[int'(owner)*DAQ_WORD_W +: DAQ_WORD_W];
  assign grant_go  = pick_found && (int'(out_space) >= MAX_PKT_WORDS);
  assign word_ok   = (int'(word_cnt) < MAX_PKT_WORDS);
  assign busy      = (state != ST_IDLE);

`ifdef DAQ_ARB_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);

  logic [WW-1:0] wdog;
  logic          wdog_hit;

  // A genuine end arriving on the last allowed cycle still wins
  assign wdog_hit = (int'(wdog) == WDOG_CYCLES - 1) && !own_end;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_go) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (own_end) state_nxt = ST_GAP;
`ifdef DAQ_ARB_WATCHDOG_EN
        if (wdog_hit) state_nxt = ST_GAP;
`endif
      end
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant, owner tracking and the registered output mux
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q        <= '0;
      daq_grant    <= '0;
      rr_ptr       <= '0;
      owner        <= '0;
      word_cnt     <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_end      <= 1'b0;
      err_overflow <= 1'b0;
`ifdef DAQ_ARB_WATCHDOG_EN
      wdog         <= '0;
      err_timeout  <= 1'b0;
`endif
    end else begin
      req_q     <= daq_req;
      daq_grant <= '0;
      out_valid <= 1'b0;
      out_end   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_go) begin
            daq_grant[pick_winner] <= 1'b1;
            owner    <= pick_winner;
            rr_ptr   <= OW'(rr_next(int'(pick_winner), NREQ));
            word_cnt <= '0;
`ifdef DAQ_ARB_WATCHDOG_EN
            wdog     <= '0;
`endif
          end
        end
        ST_BUSY: begin
`ifdef DAQ_ARB_WATCHDOG_EN
          wdog <= wdog + WW'(1);
          if (wdog_hit) begin
            out_end     <= 1'b1;
            err_timeout <= 1'b1;
          end else
`endif
          begin
            out_data <= own_data;
            out_end  <= own_end;
            // Words past the packet limit are swallowed and flagged
            if (own_valid) begin
              if (word_ok) begin
                out_valid <= 1'b1;
                word_cnt  <= word_cnt + CW'(1);
              end else begin
                err_overflow <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/daq_arbiter.md
Name: daq_arbiter

Overview:
- Shares the single DAQ upstream channel between up to NREQ producers (signal capture, stepper, encoder blocks) that use the daq_req/daq_grant/daq_data/daq_valid/daq_end handshake.
- Grants round-robin, one whole packet at a time, and only when the downstream word FIFO has room for a maximum-size packet. Producers never see backpressure.
- Muxes the granted producer's words onto one registered output stream.

Parameters:
- NREQ, 4, number of requesters (2..8)
- MAX_PKT_WORDS, 102, largest packet in 32-bit words including the 2 header words
- SPACE_BITS, 9, width of the downstream free-space count
- WDOG_CYCLES, 4096, cycles allowed from grant to daq_end before forced release

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- daq_req  in  NREQ  per-producer request level
- daq_grant  out  NREQ  per-producer one-cycle grant pulse
- daq_data  in  32*NREQ  producer words; producer i uses bits [32i+31:32i]
- daq_valid  in  NREQ  producer word strobes
- daq_end  in  NREQ  producer end-of-packet pulses (no data with end)
- out_data  out  32  muxed word
- out_valid  out  1  word strobe
- out_end  out  1  end-of-packet strobe
- out_space  in  SPACE_BITS  free words in the downstream FIFO
- busy  out  1  a packet is in flight
- owner  out  clog2(NREQ)  index of the current or last owner
- err_overflow  out  1  sticky; the owner sent more than MAX_PKT_WORDS words

Behaviour:
- Reset values: all outputs 0, rr_ptr=0, state ST_IDLE. Reset mid-packet drops the packet silently, with no out_end.
- ST_IDLE:
  - Eligible when any daq_req is high and out_space >= MAX_PKT_WORDS.
  - Winner is the first requester at or after rr_ptr, cyclic.
  - Pulse daq_grant[winner] for exactly 1 cycle and set owner=winner.
  - Set rr_ptr=winner+1, wrapping NREQ-1 -> 0.
  - Clear word_cnt and wdog. Go to ST_BUSY.
- ST_BUSY:
  - Each cycle: out_data<=daq_data[owner], out_valid<=daq_valid[owner], out_end<=daq_end[owner]. Output latency is exactly 1 cycle.
  - valid and end of non-owners are ignored.
  - Count words; the word that would make the count exceed MAX_PKT_WORDS is dropped, err_overflow is set, and out_valid stays 0 for it.
  - daq_end[owner] -> ST_GAP.
- ST_GAP: 1 cycle with no grant, so requesters can drop req. Then ST_IDLE.
- busy=1 in ST_BUSY and ST_GAP.
- A req that stays high across ST_GAP does not count as a new request until the ST_IDLE evaluation.
- daq_valid and daq_end in the same cycle from the owner: the word is forwarded and out_end is also asserted in that same output cycle.
- If out_space drops below threshold while in ST_BUSY, no effect. The threshold is checked only at grant time.
- A single requester is re-granted after ST_GAP if it still requests.
- owner is held after packet end.

Optional Feature:
- Macro DAQ_ARB_WATCHDOG_EN.
- When defined:
  - wdog counts cycles in ST_BUSY.
  - At WDOG_CYCLES without daq_end[owner], the arbiter emits out_end for 1 cycle with out_valid=0 and goes to ST_GAP.
  - It sets sticky output err_timeout (port exists only with the macro) and ignores that owner's late words.
- When undefined: ST_BUSY waits indefinitely and the wdog logic is absent.

Decomposition:
- Shared package daq_pkg: DAQ word width (32), DAQT packet-type constants, MAX_PKT_WORDS default, the arbiter state encoding ST_IDLE/ST_BUSY/ST_GAP.
- One sub-module, rr_pick: combinational round-robin priority picker (req vector, rr_ptr -> winner index, found flag). Everything else stays in daq_arbiter.

Test Plan:
- req=0b0001, out_space=200 -> grant[0] pulses 1 cycle, 2 cycles after req rises. Producer sends 5 words + end -> 5 out_valid words, same data, 1-cycle delay; out_end 1 cycle after end.
- req=0b1011 held, each producer sends 3 words + end -> grant order 0,1,3,0; ST_GAP of 1 cycle between packets.
- req=0b0001, out_space=101 -> no grant. out_space raised to 102 -> grant next cycle.
- Owner 2 sends 103 words + end -> 102 forwarded, err_overflow=1 and stays 1 until reset.
- Non-owner 1 strobes valid=1 data=0xDEADBEEF during owner 0's packet -> never appears on out_data.
- DAQ_ARB_WATCHDOG_EN, WDOG_CYCLES=16, owner sends 4 words and no end -> out_end with out_valid=0 at cycle 16 after grant, err_timeout=1, next requester granted.
